// File: rtl/key_event_if.sv
// Event port between key_event and its consumer.
//   event_valid : an event is presented (producer -> consumer)
//   event_ready : the consumer accepts the presented event (consumer -> producer)
//   event_code  : {type[1:0], key index}; type 01 press, 10 release, 11 repeat
interface key_event_if #(
    parameter int CODE_WIDTH = 4
);
    logic                  event_valid;
    logic                  event_ready;
    logic [CODE_WIDTH-1:0] event_code;

    modport master (
        output event_valid,
        output event_code,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_code,
        output event_ready
    );
endinterface

// File: rtl/key_event.sv
// key_event: turns debounced key levels into press / release / auto-repeat
// events and hands them out one at a time on a valid/ready port.
//
// Ports:
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-high
//   key_in       : debounced key levels (active level set by POLARITY)
//   held         : registered pressed state per key, active-high
//   ev           : event port (master side of key_event_if)
//   overflow     : sticky, set when an event is dropped
//   overflow_clr : clears overflow (a same-cycle drop wins)
module key_event #(
    parameter int    WIDTH         = 4,
    parameter int    IDX_WIDTH     = 2,
    parameter string POLARITY      = "LOW",
    parameter int    HOLD_CYCLES   = 25000000,
    parameter int    REPEAT_CYCLES = 5000000,
    parameter int    CNT_WIDTH     = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_in,
    output logic [WIDTH-1:0] held,
    key_event_if.master      ev,
    output logic             overflow,
    input  logic             overflow_clr
);

    localparam logic [1:0] TYPE_PRESS   = 2'b01;
    localparam logic [1:0] TYPE_RELEASE = 2'b10;
    localparam logic [1:0] TYPE_REPEAT  = 2'b11;

    localparam logic [WIDTH-1:0] INVERT =
        (POLARITY == "LOW") ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } key_state_t;

    logic [WIDTH-1:0] pressed;
    logic [WIDTH-1:0] press_edge;
    logic [WIDTH-1:0] release_edge;
    logic [WIDTH-1:0] held_reg;

    logic [WIDTH-1:0] raise_press;
    logic [WIDTH-1:0] raise_repeat;
    logic [WIDTH-1:0] raise_release;

    logic [WIDTH-1:0] pend_press_reg;
    logic [WIDTH-1:0] pend_repeat_reg;
    logic [WIDTH-1:0] pend_release_reg;
    logic [WIDTH-1:0] pend_press_next;
    logic [WIDTH-1:0] pend_repeat_next;
    logic [WIDTH-1:0] pend_release_next;

    logic [WIDTH-1:0] unload_press;
    logic [WIDTH-1:0] unload_repeat;
    logic [WIDTH-1:0] unload_release;

    logic                   sel_found;
    logic [IDX_WIDTH-1:0]   sel_idx;
    logic [1:0]             sel_type;
    logic [WIDTH-1:0]       sel_onehot;

    logic                   load;
    logic                   drop;
    logic                   valid_reg;
    logic [IDX_WIDTH+1:0]   code_reg;
    logic                   overflow_reg;

    assign pressed      = key_in ^ INVERT;
    assign press_edge   = pressed & ~held_reg;
    assign release_edge = ~pressed & held_reg;

    // Per-key press / hold / repeat state machine.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_key
        key_state_t           state_reg;
        logic [CNT_WIDTH-1:0] cnt_reg;
        logic                 expired;

        always_comb begin
            expired = 1'b0;
            case (state_reg)
                ST_HOLD:   expired = (cnt_reg == HOLD_LAST);
                ST_REPEAT: expired = (cnt_reg == REPEAT_LAST);
                default:   expired = 1'b0;
            endcase
        end

        assign raise_press[gi]   = (state_reg == ST_IDLE) && press_edge[gi];
        assign raise_release[gi] = (state_reg != ST_IDLE) && release_edge[gi];
        // A release in the same cycle as counter expiry suppresses the repeat.
        assign raise_repeat[gi]  = (state_reg != ST_IDLE) && !release_edge[gi] && expired;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (press_edge[gi]) begin
                            state_reg <= ST_HOLD;
                            cnt_reg   <= '0;
                        end
                    end
                    ST_HOLD, ST_REPEAT: begin
                        if (release_edge[gi]) begin
                            state_reg <= ST_IDLE;
                            cnt_reg   <= '0;
                        end else if (expired) begin
                            state_reg <= ST_REPEAT;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

    // Priority pick: walk from the highest index down so the lowest index
    // with anything pending is the one left standing.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_type   = 2'b00;
        sel_onehot = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_press_reg[i] || pend_repeat_reg[i] || pend_release_reg[i]) begin
                sel_found     = 1'b1;
                sel_idx       = IDX_WIDTH'(i);
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                if (pend_press_reg[i]) begin
                    sel_type = TYPE_PRESS;
                end else if (pend_repeat_reg[i]) begin
                    sel_type = TYPE_REPEAT;
                end else begin
                    sel_type = TYPE_RELEASE;
                end
            end
        end
    end

    assign load = !valid_reg || ev.event_ready;

    assign unload_press   = (load && sel_type == TYPE_PRESS)   ? sel_onehot : '0;
    assign unload_repeat  = (load && sel_type == TYPE_REPEAT)  ? sel_onehot : '0;
    assign unload_release = (load && sel_type == TYPE_RELEASE) ? sel_onehot : '0;

    // A raise onto a bit that stays set (not unloaded this edge) is lost.
    assign drop = |(raise_press   & pend_press_reg   & ~unload_press)
                | |(raise_repeat  & pend_repeat_reg  & ~unload_repeat)
                | |(raise_release & pend_release_reg & ~unload_release);

    // Set has priority over the unload-clear of the same bit.
    assign pend_press_next   = (pend_press_reg   & ~unload_press)   | raise_press;
    assign pend_repeat_next  = (pend_repeat_reg  & ~unload_repeat)  | raise_repeat;
    assign pend_release_next = (pend_release_reg & ~unload_release) | raise_release;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_reg         <= '0;
            pend_press_reg   <= '0;
            pend_repeat_reg  <= '0;
            pend_release_reg <= '0;
            valid_reg        <= 1'b0;
            code_reg         <= '0;
            overflow_reg     <= 1'b0;
        end else begin
            held_reg         <= pressed;
            pend_press_reg   <= pend_press_next;
            pend_repeat_reg  <= pend_repeat_next;
            pend_release_reg <= pend_release_next;
            if (load) begin
                valid_reg <= sel_found;
                if (sel_found) begin
                    code_reg <= {sel_type, sel_idx};
                end
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (overflow_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign held           = held_reg;
    assign ev.event_valid = valid_reg;
    assign ev.event_code  = code_reg;
    assign overflow       = overflow_reg;

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: a LOW-polarity and a HIGH-polarity instance see the
// same logical key activity and are compared against an event-level model.
module tb_key_event;

    localparam int WIDTH = 4;
    localparam int IDXW  = 2;
    localparam int CODEW = 2 + IDXW;
    localparam int HOLD  = 8;
    localparam int REP   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] key_in;      // logical levels, 0 = pressed
    logic [WIDTH-1:0] key_in_hi;
    logic [WIDTH-1:0] held_lo, held_hi;
    logic             ov_lo, ov_hi;
    logic             overflow_clr;
    logic             event_ready;

    assign key_in_hi = ~key_in;

    key_event_if #(.CODE_WIDTH(CODEW)) ev_lo ();
    key_event_if #(.CODE_WIDTH(CODEW)) ev_hi ();
    assign ev_lo.event_ready = event_ready;
    assign ev_hi.event_ready = event_ready;

    key_event #(.WIDTH(WIDTH), .IDX_WIDTH(IDXW), .POLARITY("LOW"),
                .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_WIDTH(4)) dut_lo (
        .clk(clk), .reset(reset), .key_in(key_in), .held(held_lo),
        .ev(ev_lo.master), .overflow(ov_lo), .overflow_clr(overflow_clr));

    key_event #(.WIDTH(WIDTH), .IDX_WIDTH(IDXW), .POLARITY("HIGH"),
                .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_WIDTH(4)) dut_hi (
        .clk(clk), .reset(reset), .key_in(key_in_hi), .held(held_hi),
        .ev(ev_hi.master), .overflow(ov_hi), .overflow_clr(overflow_clr));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;

    // Reference model: pending flags per key and type, a press timestamp
    // from which repeats are computed arithmetically, and the output slot.
    bit         m_held   [WIDTH];
    int         m_press_t[WIDTH];
    bit         m_pend   [WIDTH][4];
    bit         m_valid;
    logic [3:0] m_code;
    bit         m_ov;
    int         ev_cnt   [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, t);
    endtask

    task automatic model_reset();
        for (int i = 0; i < WIDTH; i++) begin
            m_held[i] = 1'b0;
            m_press_t[i] = 0;
            for (int j = 0; j < 4; j++) m_pend[i][j] = 1'b0;
        end
        m_valid = 1'b0;
        m_code  = '0;
        m_ov    = 1'b0;
    endtask

    task automatic model_edge();
        bit raise[WIDTH][4];
        bit pressed;
        bit found;
        bit load;
        bit drop;
        int fk, ft, age;
        int order[3];
        order = '{1, 3, 2};          // press, repeat, release
        drop  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < 4; j++) raise[i][j] = 1'b0;
            pressed = ~key_in[i];
            if (pressed && !m_held[i]) begin
                raise[i][1]  = 1'b1;
                m_press_t[i] = t;
            end else if (!pressed && m_held[i]) begin
                raise[i][2] = 1'b1;
            end else if (pressed) begin
                age = t - m_press_t[i];
                if (age >= HOLD && ((age - HOLD) % REP) == 0) raise[i][3] = 1'b1;
            end
        end
        load  = !m_valid || event_ready;
        found = 1'b0;
        fk    = 0;
        ft    = 0;
        for (int i = 0; i < WIDTH && !found; i++) begin
            for (int j = 0; j < 3 && !found; j++) begin
                if (m_pend[i][order[j]]) begin
                    found = 1'b1;
                    fk    = i;
                    ft    = order[j];
                end
            end
        end
        if (load && found) m_pend[fk][ft] = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 1; j < 4; j++) begin
                if (raise[i][j]) begin
                    if (m_pend[i][j]) drop = 1'b1;
                    m_pend[i][j] = 1'b1;
                end
            end
        end
        if (drop) m_ov = 1'b1;
        else if (overflow_clr) m_ov = 1'b0;
        if (load) begin
            m_valid = found;
            if (found) m_code = {ft[1:0], fk[1:0]};
        end
        for (int i = 0; i < WIDTH; i++) m_held[i] = ~key_in[i];
    endtask

    task automatic check_all();
        logic [WIDTH-1:0] mh;
        for (int i = 0; i < WIDTH; i++) mh[i] = m_held[i];
        check("held_lo", 32'(held_lo), 32'(mh));
        check("held_hi", 32'(held_hi), 32'(mh));
        check("valid_lo", 32'(ev_lo.event_valid), 32'(m_valid));
        check("valid_hi", 32'(ev_hi.event_valid), 32'(m_valid));
        if (m_valid) begin
            check("code_lo", 32'(ev_lo.event_code), 32'(m_code));
            check("code_hi", 32'(ev_hi.event_code), 32'(m_code));
        end
        check("ovf_lo", 32'(ov_lo), 32'(m_ov));
        check("ovf_hi", 32'(ov_hi), 32'(m_ov));
    endtask

    // One clock edge: advance the model with the values present at the
    // edge, then compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        t++;
        if (reset) model_reset();
        else model_edge();
        #1;
        check_all();
        if (ev_lo.event_valid) ev_cnt[ev_lo.event_code]++;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 16; i++) ev_cnt[i] = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(ev_lo.event_valid), 32'd0);
        check({tag, "_code"},  32'(ev_lo.event_code),  32'd0);
        check({tag, "_held"},  32'(held_lo),           32'd0);
        check({tag, "_ovf"},   32'(ov_lo),             32'd0);
        check({tag, "_valid_hi"}, 32'(ev_hi.event_valid), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        key_in       = '1;
        event_ready  = 1'b1;
        overflow_clr = 1'b0;
        model_reset();
        clear_counts();

        // Reset state
        repeat (3) step();
        check_zero_outputs("reset");
        reset = 1'b0;
        repeat (3) step();

        // Single tap on key 2
        key_in[2] = 1'b0;
        step();
        check("tap_held_a", 32'(held_lo[2]), 32'd1);
        check("tap_novalid", 32'(ev_lo.event_valid), 32'd0);
        step();
        check("tap_press_valid", 32'(ev_lo.event_valid), 32'd1);
        check("tap_press_code", 32'(ev_lo.event_code), 32'b0110);
        check("tap_press_code_hi", 32'(ev_hi.event_code), 32'b0110);
        step();
        check("tap_one_cycle", 32'(ev_lo.event_valid), 32'd0);
        check("tap_held_c", 32'(held_lo[2]), 32'd1);
        key_in[2] = 1'b1;
        step();
        check("tap_held_off", 32'(held_lo[2]), 32'd0);
        step();
        check("tap_rel_valid", 32'(ev_lo.event_valid), 32'd1);
        check("tap_rel_code", 32'(ev_lo.event_code), 32'b1010);
        repeat (3) step();

        // Auto-repeat on key 0
        clear_counts();
        key_in[0] = 1'b0;
        repeat (20) step();
        key_in[0] = 1'b1;
        repeat (3) step();
        check("rep_press_cnt", 32'(ev_cnt[4'b0100]), 32'd1);
        check("rep_repeat_cnt", 32'(ev_cnt[4'b1100]), 32'd3);
        check("rep_release_cnt", 32'(ev_cnt[4'b1000]), 32'd1);

        // Simultaneous presses on keys 3 and 1
        key_in[3] = 1'b0;
        key_in[1] = 1'b0;
        step();
        step();
        check("sim_first", 32'(ev_lo.event_code), 32'b0101);
        step();
        check("sim_second_valid", 32'(ev_lo.event_valid), 32'd1);
        check("sim_second", 32'(ev_lo.event_code), 32'b0111);
        key_in[3] = 1'b1;
        key_in[1] = 1'b1;
        repeat (4) step();

        // Backpressure: two taps on key 0 while the consumer stalls
        event_ready = 1'b0;
        key_in[0] = 1'b0; repeat (2) step();
        key_in[0] = 1'b1; repeat (2) step();
        key_in[0] = 1'b0; repeat (2) step();
        key_in[0] = 1'b1; repeat (2) step();
        check("bp_valid", 32'(ev_lo.event_valid), 32'd1);
        check("bp_code_stable", 32'(ev_lo.event_code), 32'b0100);
        check("bp_overflow", 32'(ov_lo), 32'd1);
        event_ready = 1'b1;
        repeat (5) step();
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("ovf_cleared", 32'(ov_lo), 32'd0);

        // Reset while key 1 is repeating with events pending
        event_ready = 1'b0;
        key_in[1] = 1'b0;
        repeat (14) step();
        reset = 1'b1;
        model_reset();
        #1;
        check_zero_outputs("async_rst");
        repeat (2) step();
        event_ready = 1'b1;
        reset = 1'b0;
        clear_counts();
        repeat (12) step();
        check("rst_press_cnt", 32'(ev_cnt[4'b0101]), 32'd1);
        check("rst_repeat_cnt", 32'(ev_cnt[4'b1101]), 32'd1);
        check("rst_release_cnt", 32'(ev_cnt[4'b1001]), 32'd0);
        key_in[1] = 1'b1;
        repeat (3) step();

        // Randomised activity
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                int k;
                k = $urandom_range(0, WIDTH - 1);
                key_in[k] = ~key_in[k];
            end
            event_ready  = ($urandom_range(0, 3) != 0);
            overflow_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                check("rnd_rst_valid", 32'(ev_lo.event_valid), 32'd0);
                step();
                reset = 1'b0;
            end else begin
                step();
            end
        end

        // Drain
        key_in       = '1;
        event_ready  = 1'b1;
        overflow_clr = 1'b0;
        repeat (20) step();
        check("drain_idle", 32'(ev_lo.event_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
